// File: rtl/instr_decode_queue.sv
// instr_decode_queue: registered Tinker instruction decoder feeding a DEPTH-entry
// FIFO toward execute. Decodes at accept time, tags each record with an
// accept-order sequence number and closes intake after a halt.
module instr_decode_queue #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned OP_W    = 5,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned LIT_W   = 12,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned SEQ_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_W-1:0]       in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OP_W-1:0]          out_opcode,
  output logic [REG_W-1:0]         out_rd,
  output logic [REG_W-1:0]         out_rs,
  output logic [REG_W-1:0]         out_rt,
  output logic [DATA_W-1:0]        out_lit_zext,
  output logic [DATA_W-1:0]        out_lit_sext,
  output logic                     out_rt_passed,
  output logic                     out_halt,
  output logic                     out_illegal,
  output logic [SEQ_W-1:0]         out_seq,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     halted
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned RD_LSB = INSTR_W - OP_W - REG_W;
  localparam int unsigned RS_LSB = RD_LSB - REG_W;
  localparam int unsigned RT_LSB = RS_LSB - REG_W;

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [DATA_W-1:0] lit_zext;
    logic [DATA_W-1:0] lit_sext;
    logic              rt_passed;
    logic              halt;
    logic              illegal;
    logic [SEQ_W-1:0]  seq;
  } rec_t;

  rec_t             mem_q [DEPTH];
  rec_t             out_rec_q, out_rec_d;
  rec_t             dec;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             halted_q, halted_d;
  logic             out_valid_q, out_valid_d;
  logic [LIT_W-1:0] lit;
  logic             full, push, pop;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign in_ready = !reset && !full && !halted_q && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid_q && out_ready && !flush;

  // Field extraction and flag derivation for the incoming word
  always_comb begin
    dec           = '0;
    lit           = in_instr[LIT_W-1:0];
    dec.opcode    = in_instr[INSTR_W-1 -: OP_W];
    dec.rd        = in_instr[RD_LSB +: REG_W];
    dec.rs        = in_instr[RS_LSB +: REG_W];
    dec.rt        = in_instr[RT_LSB +: REG_W];
    dec.lit_zext  = DATA_W'(lit);
    dec.lit_sext  = {{(DATA_W-LIT_W){lit[LIT_W-1]}}, lit};
    case (dec.opcode)
      OP_W'(5'h05), OP_W'(5'h07), OP_W'(5'h0A), OP_W'(5'h10),
      OP_W'(5'h12), OP_W'(5'h13), OP_W'(5'h19), OP_W'(5'h1B):
        dec.rt_passed = 1'b0;
      default:
        dec.rt_passed = 1'b1;
    endcase
    dec.halt      = (dec.opcode == OP_W'(5'h0F)) && (lit == '0);
    dec.illegal   = (dec.opcode > OP_W'(5'h1D));
    dec.seq       = seq_q;
  end

  // Next-state for pointers, counters, halt latch and the registered head record
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    cnt_d       = cnt_q;
    seq_d       = seq_q;
    halted_d    = halted_q;
    out_valid_d = out_valid_q;
    out_rec_d   = out_rec_q;
    if (flush) begin
      head_d      = '0;
      tail_d      = '0;
      cnt_d       = '0;
      halted_d    = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
        seq_d  = seq_q + SEQ_W'(1);
        if (dec.halt) halted_d = 1'b1;
      end
      if (pop) head_d = head_q + PTR_W'(1);
      cnt_d       = cnt_q + CNT_W'(push) - CNT_W'(pop);
      out_valid_d = (cnt_d != '0);
      // New head is the incoming word when it lands on the head slot
      if (cnt_d != '0) begin
        if (push && (tail_q == head_d)) out_rec_d = dec;
        else                            out_rec_d = mem_q[head_d];
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      seq_q       <= '0;
      halted_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_rec_q   <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      seq_q       <= seq_d;
      halted_q    <= halted_d;
      out_valid_q <= out_valid_d;
      out_rec_q   <= out_rec_d;
    end
  end

  // FIFO storage, written at the tail on accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[tail_q] <= dec;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_opcode    = out_rec_q.opcode;
  assign out_rd        = out_rec_q.rd;
  assign out_rs        = out_rec_q.rs;
  assign out_rt        = out_rec_q.rt;
  assign out_lit_zext  = out_rec_q.lit_zext;
  assign out_lit_sext  = out_rec_q.lit_sext;
  assign out_rt_passed = out_rec_q.rt_passed;
  assign out_halt      = out_rec_q.halt;
  assign out_illegal   = out_rec_q.illegal;
  assign out_seq       = out_rec_q.seq;
  assign occupancy     = cnt_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Testbench for instr_decode_queue with default parameters: directed steps,
// a reference decoder and a queue scoreboard of expected head records.
module tb_instr_decode_queue;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_instr;
  logic [4:0]  out_opcode, out_rd, out_rs, out_rt;
  logic [63:0] out_lit_zext, out_lit_sext;
  logic        out_rt_passed, out_halt, out_illegal, halted;
  logic [7:0]  out_seq;
  logic [2:0]  occupancy;

  instr_decode_queue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
    .out_lit_zext(out_lit_zext), .out_lit_sext(out_lit_sext),
    .out_rt_passed(out_rt_passed), .out_halt(out_halt), .out_illegal(out_illegal),
    .out_seq(out_seq), .occupancy(occupancy), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  op, rd, rs, rt;
    logic [63:0] zx, sx;
    logic        rtp, halt, ill;
    logic [7:0]  seq;
  } rec_t;

  rec_t       sbq[$];
  rec_t       last_rec;
  logic [7:0] exp_seq;
  logic       exp_halted;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t ref_dec(input logic [31:0] w, input logic [7:0] s);
    rec_t r;
    logic [11:0] l;
    l     = w[11:0];
    r.op  = w[31:27];
    r.rd  = w[26:22];
    r.rs  = w[21:17];
    r.rt  = w[16:12];
    r.zx  = {52'h0, l};
    r.sx  = {{52{l[11]}}, l};
    r.rtp = !(r.op inside {5'h05, 5'h07, 5'h0A, 5'h10, 5'h12, 5'h13, 5'h19, 5'h1B});
    r.halt = (r.op == 5'h0F) && (l == 12'h0);
    r.ill = (r.op > 5'h1D);
    r.seq = s;
    return r;
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [11:0] l);
    return {op, rd, rs, rt, l};
  endfunction

  // One clock: drive at negedge, compare outputs against model, advance model
  task automatic cycle(input logic v, input logic [31:0] w, input logic r, input logic f);
    rec_t h;
    logic exp_ir, exp_ov, acc, pp;
    @(negedge clk);
    in_valid = v; in_instr = w; out_ready = r; flush = f;
    #1;
    exp_ir = (sbq.size() < 4) && !exp_halted && !f;
    exp_ov = (sbq.size() > 0);
    h = exp_ov ? sbq[0] : last_rec;
    if (exp_ov) last_rec = sbq[0];
    chk("in_ready", 64'(in_ready), 64'(exp_ir));
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    chk("occupancy", 64'(occupancy), 64'(sbq.size()));
    chk("halted", 64'(halted), 64'(exp_halted));
    chk("opcode", 64'(out_opcode), 64'(h.op));
    chk("rd", 64'(out_rd), 64'(h.rd));
    chk("rs", 64'(out_rs), 64'(h.rs));
    chk("rt", 64'(out_rt), 64'(h.rt));
    chk("lit_zext", out_lit_zext, h.zx);
    chk("lit_sext", out_lit_sext, h.sx);
    chk("rt_passed", 64'(out_rt_passed), 64'(h.rtp));
    chk("out_halt", 64'(out_halt), 64'(h.halt));
    chk("illegal", 64'(out_illegal), 64'(h.ill));
    chk("seq", 64'(out_seq), 64'(h.seq));
    acc = v && exp_ir;
    pp  = exp_ov && r && !f;
    if (f) begin
      sbq.delete();
      exp_halted = 1'b0;
    end else begin
      if (pp) void'(sbq.pop_front());
      if (acc) begin
        sbq.push_back(ref_dec(w, exp_seq));
        if (sbq[sbq.size()-1].halt) exp_halted = 1'b1;
        exp_seq = exp_seq + 8'd1;
      end
    end
  endtask

  // Asynchronous reset pulse taken mid-cycle; state must clear without a clock edge
  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_seq", 64'(out_seq), 64'd0);
    chk("rst_opcode", 64'(out_opcode), 64'd0);
    sbq.delete();
    last_rec   = '0;
    exp_seq    = 8'd0;
    exp_halted = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    last_rec = '0; exp_seq = 8'd0; exp_halted = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();
    cycle(0, 0, 0, 0);

    // First accept after reset: fields and one-cycle latency
    cycle(1, 32'h2A84_5007, 0, 0);
    @(posedge clk); #1;
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_opcode", 64'(out_opcode), 64'h05);
    chk("t1_rd", 64'(out_rd), 64'd10);
    chk("t1_rs", 64'(out_rs), 64'd2);
    chk("t1_rt", 64'(out_rt), 64'd5);
    chk("t1_rtp", 64'(out_rt_passed), 64'd0);
    chk("t1_zext", out_lit_zext, 64'd7);
    chk("t1_sext", out_lit_sext, 64'd7);
    chk("t1_seq", 64'(out_seq), 64'd0);
    cycle(0, 0, 1, 0);

    // Literal extension and rt select
    cycle(1, mk(5'h19, 5'd1, 5'd2, 5'd3, 12'hFFF), 1, 0);
    @(posedge clk); #1;
    chk("t2_zext", out_lit_zext, 64'h0000_0000_0000_0FFF);
    chk("t2_sext", out_lit_sext, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t2_rtp19", 64'(out_rt_passed), 64'd0);
    cycle(1, mk(5'h18, 5'd1, 5'd2, 5'd3, 12'hFFF), 1, 0);
    @(posedge clk); #1;
    chk("t2_rtp18", 64'(out_rt_passed), 64'd1);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);

    // Fill to full with consumer stalled, then drain in order
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, mk(5'h01, 5'(i), 5'(i+1), 5'(i+2), 12'(i*3)), 0, 0);
    @(posedge clk); #1;
    chk("full_occ", 64'(occupancy), 64'd4);
    chk("full_ready", 64'(in_ready), 64'd0);
    chk("full_seq", 64'(out_seq), 64'd0);
    w = mk(5'h01, 5'd4, 5'd5, 5'd6, 12'd12);
    cycle(1, w, 1, 0);
    cycle(1, w, 1, 0);
    repeat (5) cycle(0, 0, 1, 0);

    // Halt closes intake; queued records drain; flush reopens
    cycle(1, 32'h7800_0000, 0, 0);
    @(posedge clk); #1;
    chk("halt_halted", 64'(halted), 64'd1);
    chk("halt_ready", 64'(in_ready), 64'd0);
    chk("halt_head", 64'(out_halt), 64'd1);
    cycle(1, mk(5'h02, 5'd1, 5'd1, 5'd1, 12'd1), 0, 0);
    cycle(1, mk(5'h03, 5'd1, 5'd1, 5'd1, 12'd1), 0, 0);
    repeat (3) cycle(1, mk(5'h04, 5'd2, 5'd2, 5'd2, 12'd2), 1, 0);
    cycle(0, 0, 0, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("unhalt_halted", 64'(halted), 64'd0);
    chk("unhalt_ready", 64'(in_ready), 64'd1);

    // Flush with pending push and pop in the same cycle
    for (int i = 0; i < 3; i++) cycle(1, mk(5'h06, 5'(i), 5'd0, 5'd0, 12'h800), 0, 0);
    cycle(1, mk(5'h08, 5'd9, 5'd9, 5'd9, 12'd9), 1, 1);
    @(posedge clk); #1;
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    cycle(1, mk(5'h09, 5'd3, 5'd3, 5'd3, 12'd3), 1, 0);

    // Illegal opcode is queued and flagged
    cycle(1, mk(5'h1F, 5'd7, 5'd8, 5'd9, 12'h123), 1, 0);
    @(posedge clk); #1;
    chk("ill_valid", 64'(out_valid), 64'd1);
    chk("ill_flag", 64'(out_illegal), 64'd1);
    cycle(0, 0, 1, 0);

    // Sustained streaming through sequence wrap
    for (int i = 0; i < 300; i++) begin
      w = $urandom;
      if (w[31:27] == 5'h0F) w[0] = 1'b1;
      cycle(1, w, (i % 7) != 3, 0);
    end
    repeat (5) cycle(0, 0, 1, 0);

    // Reset in the middle of traffic
    cycle(1, mk(5'h0B, 5'd1, 5'd2, 5'd3, 12'd4), 0, 0);
    cycle(1, mk(5'h0C, 5'd1, 5'd2, 5'd3, 12'd4), 0, 0);
    do_reset();
    cycle(1, mk(5'h0D, 5'd1, 5'd2, 5'd3, 12'd4), 1, 0);
    repeat (2) cycle(0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
